// File: rtl/tanimoto_stim_gen_if.sv
// Stream interface between tanimoto_stim_gen (master) and tanimoto_top (slave).
// Carries the BUS_WIDTH beat, its valid/last qualifiers and the downstream ready.
interface tanimoto_stim_gen_if #(
  parameter int BUS_WIDTH = 128
);
  logic [BUS_WIDTH-1:0] o_Vector;
  logic                 o_Valid;
  logic                 o_Last;
  logic                 i_Ready;

  modport master (output o_Vector, output o_Valid, output o_Last, input i_Ready);
  modport slave  (input  o_Vector, input  o_Valid, input  o_Last, output i_Ready);
endinterface

// File: rtl/tanimoto_stim_gen.sv
// Stimulus engine for tanimoto_top bring-up: loads the threshold BRAM with a
// k -> k+1 ramp, then streams REF+CMP vectors of pseudo-random 32-bit lane
// LFSR data over a valid/ready handshake with optional idle gaps.
// Optional feature macro: STIM_CHECKSUM_EN (XOR checksum of accepted beats).
module tanimoto_stim_gen #(
  parameter int          BUS_WIDTH    = 128,
  parameter int          VECTOR_WIDTH = 920,
  parameter int          CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int          REF_VEC_NO   = 8,
  parameter int          CMP_VEC_NO   = 128,
  parameter int          GAP_WIDTH    = 4,
  parameter logic [31:0] LFSR_SEED    = 32'hACE12468
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_Start,
  input  logic [GAP_WIDTH-1:0]   i_GapCycles,
  tanimoto_stim_gen_if.master    bus,
  output logic [CNT_WIDTH-1:0]   o_BRAM_Addr,
  output logic [CNT_WIDTH:0]     o_BRAM_Din,
  output logic                   o_BRAM_WrEn,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [BUS_WIDTH-1:0]   o_Checksum
);

  localparam int unsigned VB        = VECTOR_WIDTH / 8;
  localparam int unsigned REF_BITS  = REF_VEC_NO * VB * 8;
  localparam int unsigned CMP_BITS  = CMP_VEC_NO * VB * 8;
  localparam int unsigned REF_BEATS = (REF_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned CMP_BEATS = (CMP_BITS + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned TOTAL     = REF_BEATS + CMP_BEATS;
  localparam int unsigned BEAT_W    = $clog2(TOTAL + 1);
  localparam int unsigned LANES     = BUS_WIDTH / 32;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_GAP,
    S_DONE
  } state_t;

  state_t                r_State;
  logic [BUS_WIDTH-1:0]  r_Lfsr;
  logic [BEAT_W-1:0]     r_Beat;
  logic [GAP_WIDTH-1:0]  r_Gap;
  logic [GAP_WIDTH-1:0]  r_GapCnt;
  logic [CNT_WIDTH-1:0]  r_Addr;
  logic [CNT_WIDTH:0]    r_Din;
  logic                  r_WrEn;
  logic                  r_Valid;
  logic                  r_Busy;
  logic                  r_Done;

  logic [BUS_WIDTH-1:0]  w_Seed;
  logic [BUS_WIDTH-1:0]  w_LfsrNext;
  logic [BUS_WIDTH-1:0]  w_Vector;
  logic                  w_Accept;
  logic                  w_StartReq;

  // Per-lane seeds and one Galois step of every lane
  always_comb begin
    w_Seed     = '0;
    w_LfsrNext = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_Seed[32*k +: 32]     = LFSR_SEED + 32'(k);
      w_LfsrNext[32*k +: 32] = {1'b0, r_Lfsr[32*k+1 +: 31]}
                             ^ (r_Lfsr[32*k] ? LFSR_MASK : 32'h0);
    end
  end

  // Data is gated by valid so every output reads 0 out of reset and in gaps
  assign w_Vector   = r_Valid ? r_Lfsr : '0;
  assign w_Accept   = r_Valid & bus.i_Ready;
  assign w_StartReq = (r_State == S_IDLE) & i_Start;

  assign bus.o_Vector = w_Vector;
  assign bus.o_Valid  = r_Valid;
  assign bus.o_Last   = r_Valid & (r_Beat == BEAT_W'(TOTAL - 1));
  assign o_BRAM_Addr  = r_Addr;
  assign o_BRAM_Din   = r_Din;
  assign o_BRAM_WrEn  = r_WrEn;
  assign o_Busy       = r_Busy;
  assign o_Done       = r_Done;

  // Run sequencer: IDLE -> LOAD -> STREAM/GAP -> DONE -> IDLE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_State  <= S_IDLE;
      r_Lfsr   <= w_Seed;
      r_Beat   <= '0;
      r_Gap    <= '0;
      r_GapCnt <= '0;
      r_Addr   <= '0;
      r_Din    <= '0;
      r_WrEn   <= 1'b0;
      r_Valid  <= 1'b0;
      r_Busy   <= 1'b0;
      r_Done   <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_Gap   <= i_GapCycles;
            r_Lfsr  <= w_Seed;
            r_Beat  <= '0;
            r_Addr  <= '0;
            r_Din   <= (CNT_WIDTH+1)'(1);
            r_WrEn  <= 1'b1;
            r_Busy  <= 1'b1;
            r_State <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_Addr == CNT_WIDTH'(VECTOR_WIDTH - 1)) begin
            r_WrEn  <= 1'b0;
            r_Addr  <= '0;
            r_Din   <= '0;
            r_Valid <= 1'b1;
            r_State <= S_STREAM;
          end else begin
            r_Addr <= r_Addr + 1'b1;
            r_Din  <= r_Din + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_Accept) begin
            r_Lfsr <= w_LfsrNext;
            r_Beat <= r_Beat + 1'b1;
            if (r_Beat == BEAT_W'(TOTAL - 1)) begin
              r_Valid <= 1'b0;
              r_Busy  <= 1'b0;
              r_Done  <= 1'b1;
              r_State <= S_DONE;
            end else if (r_Gap != '0) begin
              r_Valid  <= 1'b0;
              r_GapCnt <= r_Gap;
              r_State  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_GapCnt == GAP_WIDTH'(1)) begin
            r_Valid <= 1'b1;
            r_State <= S_STREAM;
          end else begin
            r_GapCnt <= r_GapCnt - 1'b1;
          end
        end
        S_DONE: begin
          r_Done  <= 1'b0;
          r_State <= S_IDLE;
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

`ifdef STIM_CHECKSUM_EN
  logic [BUS_WIDTH-1:0] r_Checksum;

  // Running XOR of accepted beats, cleared when a run starts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_Checksum <= '0;
    end else if (w_StartReq) begin
      r_Checksum <= '0;
    end else if (w_Accept) begin
      r_Checksum <= r_Checksum ^ w_Vector;
    end
  end

  assign o_Checksum = r_Checksum;
`else
  assign o_Checksum = '0;
`endif

endmodule

// File: tb/tb_tanimoto_stim_gen.sv
// Scoreboard bench for tanimoto_stim_gen: a reference model generates the whole
// expected beat sequence per run into a queue; a negedge monitor pops and
// compares accepted beats, BRAM writes and run timing.
module tb_tanimoto_stim_gen;

  localparam int unsigned BW     = 128;
  localparam int unsigned VW     = 920;
  localparam int unsigned CW     = 10;
  localparam int unsigned GW     = 4;
  localparam int unsigned TOTAL  = 978;
  localparam logic [31:0] SEED   = 32'hACE12468;
  localparam logic [31:0] MASK   = 32'h80200003;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_Start;
  logic [GW-1:0] i_GapCycles;
  logic [CW-1:0] o_BRAM_Addr;
  logic [CW:0]   o_BRAM_Din;
  logic          o_BRAM_WrEn;
  logic          o_Busy;
  logic          o_Done;
  logic [BW-1:0] o_Checksum;

  tanimoto_stim_gen_if #(.BUS_WIDTH(BW)) bus ();

  tanimoto_stim_gen #(
    .BUS_WIDTH    (BW),
    .VECTOR_WIDTH (VW),
    .REF_VEC_NO   (8),
    .CMP_VEC_NO   (128),
    .GAP_WIDTH    (GW),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_Start     (i_Start),
    .i_GapCycles (i_GapCycles),
    .bus         (bus),
    .o_BRAM_Addr (o_BRAM_Addr),
    .o_BRAM_Din  (o_BRAM_Din),
    .o_BRAM_WrEn (o_BRAM_WrEn),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Checksum  (o_Checksum)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   cyc   = 0;
  logic [BW-1:0] sb[$];
  bit            rand_ready = 0;

  // per-run monitor state
  int unsigned   wr_cnt, beats, done_cnt, cw_cyc, c0_cyc, cd_cyc;
  bit            seen_valid, stalled;
  logic [BW-1:0] prev_vec;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? MASK : 32'h0);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: changes just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    bus.i_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      if (o_BRAM_WrEn) begin
        if (wr_cnt == 0) begin
          cw_cyc = cyc;
          check("busy_at_load", BW'(o_Busy), BW'(1));
        end
        check("bram_addr", BW'(o_BRAM_Addr), BW'(wr_cnt));
        check("bram_din", BW'(o_BRAM_Din), BW'(wr_cnt + 1));
        wr_cnt++;
      end
      if (stalled) begin
        check("stall_valid", BW'(bus.o_Valid), BW'(1));
        if (bus.o_Valid) check("stall_data", bus.o_Vector, prev_vec);
      end
      if (bus.o_Valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          c0_cyc     = cyc;
          check("beat0_lane0", BW'(bus.o_Vector[31:0]), BW'(32'hACE12468));
          check("beat0_lane3", BW'(bus.o_Vector[127:96]), BW'(32'hACE1246B));
        end
        if (sb.size() == 0) begin
          check("unexpected_beat", BW'(1), BW'(0));
        end else begin
          check("beat_data", bus.o_Vector, sb[0]);
          check("beat_last", BW'(bus.o_Last), BW'(sb.size() == 1));
          if (bus.i_Ready) begin
            void'(sb.pop_front());
            beats++;
          end
        end
      end else if (bus.o_Last) begin
        check("last_without_valid", BW'(1), BW'(0));
      end
      stalled  = bus.o_Valid && !bus.i_Ready;
      prev_vec = bus.o_Vector;
      if (o_Done) begin
        done_cnt++;
        cd_cyc = cyc;
        check("busy_at_done", BW'(o_Busy), BW'(0));
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, BW'(bus.o_Valid), BW'(0));
    check({tag, "_last"},  BW'(bus.o_Last), BW'(0));
    check({tag, "_vector"}, bus.o_Vector, BW'(0));
    check({tag, "_wren"},  BW'(o_BRAM_WrEn), BW'(0));
    check({tag, "_addr"},  BW'(o_BRAM_Addr), BW'(0));
    check({tag, "_din"},   BW'(o_BRAM_Din), BW'(0));
    check({tag, "_busy"},  BW'(o_Busy), BW'(0));
    check({tag, "_done"},  BW'(o_Done), BW'(0));
    check({tag, "_cksum"}, o_Checksum, BW'(0));
  endtask

  task automatic do_run(input int unsigned gap, input bit rnd, input int unsigned abort_at,
                        input bit poke);
    logic [31:0]   lane[4];
    logic [BW-1:0] beat, ck, exp_ck;
    bit            finished = 0, aborted = 0, p1 = 0, p2 = 0;
    // reference model: whole run's beat sequence from seeds and LFSR rule
    sb.delete();
    ck = '0;
    for (int k = 0; k < 4; k++) lane[k] = SEED + 32'(k);
    for (int b = 0; b < int'(TOTAL); b++) begin
      beat = {lane[3], lane[2], lane[1], lane[0]};
      sb.push_back(beat);
      ck ^= beat;
      for (int k = 0; k < 4; k++) lane[k] = step(lane[k]);
    end
    wr_cnt = 0; beats = 0; done_cnt = 0; seen_valid = 0; stalled = 0;
    rand_ready = rnd;
    @(posedge clk); #1;
    i_GapCycles = GW'(gap);
    i_Start     = 1'b1;
    @(posedge clk); #1;
    i_Start     = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) begin finished = 1; break; end
      if (abort_at != 0 && beats == abort_at) begin
        rstn = 1'b0;
        #1;
        check_idle("abort");
        @(posedge clk); #1;
        rstn    = 1'b1;
        aborted = 1;
        break;
      end
      if (poke && !p1 && wr_cnt == 100) begin i_Start = 1'b1; p1 = 1; end
      else if (poke && !p2 && beats == 50) begin i_Start = 1'b1; p2 = 1; end
      else i_Start = 1'b0;
    end
    i_Start = 1'b0;
    if (aborted) begin
      repeat (4) @(negedge clk);
      check("abort_no_done", BW'(done_cnt), BW'(0));
      sb.delete();
      return;
    end
    if (!finished) begin
      check("timeout", BW'(0), BW'(1));
      return;
    end
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", BW'(done_cnt), BW'(1));
    check("bram_writes", BW'(wr_cnt), BW'(VW));
    check("beats_total", BW'(beats), BW'(TOTAL));
    check("sb_empty", BW'(sb.size()), BW'(0));
    check("load_len", BW'(c0_cyc - cw_cyc), BW'(VW));
    if (!rnd) check("stream_len", BW'(cd_cyc - c0_cyc), BW'(TOTAL + (TOTAL - 1) * gap));
    check("busy_after", BW'(o_Busy), BW'(0));
`ifdef STIM_CHECKSUM_EN
    exp_ck = ck;
`else
    exp_ck = '0;
`endif
    check("checksum", o_Checksum, exp_ck);
  endtask

  initial begin
    rstn        = 1'b0;
    i_Start     = 1'b0;
    i_GapCycles = '0;
    bus.i_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rstn = 1'b1;
    do_run(0, 0, 0, 0);
    do_run(3, 0, 0, 0);
    do_run($urandom_range(0, 2), 1, 0, 0);
    do_run(0, 0, 500, 0);
    do_run(1, 1, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tanimoto_stim_gen.md
Name: tanimoto_stim_gen

Overview:
- Synthesizable stimulus engine for tanimoto_top bring-up and on-board self-test.
- On i_Start it performs two phases:
  - Loads the threshold BRAM with a deterministic ramp.
  - Streams REF_VEC_NO reference vectors, then CMP_VEC_NO comparison vectors, as pseudo-random BUS_WIDTH beats over a valid/ready handshake, with programmable idle gaps for sparse-traffic testing.
- Its outputs connect directly to tanimoto_top's vector input and BRAM write ports.

Parameters:
- BUS_WIDTH, 128, stream beat width; must be a multiple of 32.
- VECTOR_WIDTH, 920, fingerprint width in bits; must be a multiple of 8.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), threshold address width.
- REF_VEC_NO, 8, reference vectors per run.
- CMP_VEC_NO, 128, comparison vectors per run.
- GAP_WIDTH, 4, width of the idle-gap control.
- LFSR_SEED, 32'hACE12468, base seed; lane k uses LFSR_SEED+k and must be nonzero.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_Start  in  1  run request; sampled in IDLE only.
- i_GapCycles  in  GAP_WIDTH  idle cycles after each accepted beat; sampled at start.
- i_Ready  in  1  downstream accept.
- o_Vector  out  BUS_WIDTH  stream data.
- o_Valid  out  1  stream data valid.
- o_Last  out  1  high on the final beat of the run.
- o_BRAM_Addr  out  CNT_WIDTH  threshold write address.
- o_BRAM_Din  out  CNT_WIDTH+1  threshold write data.
- o_BRAM_WrEn  out  1  threshold write strobe.
- o_Busy  out  1  run in progress.
- o_Done  out  1  one-cycle pulse at run end.
- o_Checksum  out  BUS_WIDTH  XOR of accepted beats (see Optional Feature).

Behaviour:
- Derived constants:
  - VB = VECTOR_WIDTH/8.
  - REF_BEATS = ceil(REF_VEC_NO*VB*8/BUS_WIDTH).
  - CMP_BEATS = ceil(CMP_VEC_NO*VB*8/BUS_WIDTH).
  - TOTAL = REF_BEATS + CMP_BEATS. Defaults: 58 + 920 = 978.
- Reset (async, rstn=0): FSM goes to IDLE; every output is 0; the beat counter and gap counter are 0; lane LFSRs are loaded with their seeds. Reset mid-run aborts immediately, and no o_Done is issued.
- FSM states: IDLE -> LOAD -> GAP/STREAM -> DONE -> IDLE.
- IDLE:
  - i_Start=1 registers i_GapCycles, reseeds all LFSRs and enters LOAD on the next cycle.
  - o_Busy rises in the same cycle as the LOAD entry.
  - i_Start is ignored in every state except IDLE.
- LOAD:
  - For k = 0..VECTOR_WIDTH-1 (one per cycle): o_BRAM_WrEn=1, o_BRAM_Addr=k, o_BRAM_Din=k+1.
  - After the last write, o_BRAM_WrEn drops and the FSM enters STREAM.
  - LOAD lasts exactly VECTOR_WIDTH cycles.
- STREAM:
  - o_Valid=1.
  - o_Vector is the concatenation of BUS_WIDTH/32 lane LFSRs; lane 0 is in bits [31:0].
  - Data is held stable while o_Valid=1 and i_Ready=0. There is no drop and no retraction.
  - A beat is accepted when o_Valid and i_Ready are both 1 on a clock edge. On acceptance:
    - All lanes advance one step of a Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
    - The beat counter increments.
  - o_Last=1 exactly when the beat counter equals TOTAL-1 and o_Valid=1.
  - After acceptance with the counter at TOTAL-1, the FSM enters DONE.
  - Otherwise, if the registered gap is G>0, the FSM enters GAP. If G=0 it stays in STREAM, giving back-to-back beats with no bubble.
- GAP: o_Valid=0 for exactly G cycles, then return to STREAM.
- DONE: o_Done=1 for one cycle; o_Busy falls in that cycle; the next state is IDLE.
- i_Ready=1 while o_Valid=0 has no effect.
- The reference/comparison boundary is not signalled; downstream counts beats.
- A new run is byte-identical to the previous one: the LFSRs are reseeded at every start.

Optional Feature:
- Macro: STIM_CHECKSUM_EN.
- When defined:
  - o_Checksum clears at start.
  - It XORs in o_Vector on every accepted beat and holds its value after DONE until the next start.
- When undefined: o_Checksum is constant 0 and no accumulator logic is synthesised.

Test Plan:
- Defaults, i_GapCycles=0, i_Ready=1: 920 consecutive BRAM writes, with addr 919 carrying din 920; then 978 beats in 978 cycles; o_Last only on beat 977; o_Done exactly 1 cycle after beat 977 is accepted.
- First-beat check: lane 0 of beat 0 = 32'hACE12468 and lane 3 = 32'hACE1246B; beat 1 lane 0 = seed advanced once by mask 32'h80200003, matching the bench model.
- i_GapCycles=3, i_Ready=1: exactly 3 idle cycles between beats; streaming phase lasts 978 + 977*3 = 3909 cycles.
- i_Ready toggled randomly (50%): o_Vector and o_Valid are stable whenever a stall occurs; the sequence and final count of 978 match the no-stall run, and o_Last stays on beat 977.
- Reset mid-run: rstn low at beat 500 clears all outputs asynchronously; a new i_Start reproduces beat 0 = seed pattern; i_Start pulses during LOAD or STREAM are ignored.
- With STIM_CHECKSUM_EN: o_Checksum after DONE equals the bench-computed XOR of all 978 beats; without the macro, o_Checksum remains 0 throughout.
